divider_32by16_seq: RTL and testbench

Sequential unsigned restoring divider: 32-bit dividend by 16-bit divisor, producing a 32-bit quotient and 16-bit remainder.
- Inverse datapath of the 16x16 fast multipliers. Feeding a multiplier's `product` and `B` back in recovers `A` with zero remainder, so the block doubles as a self-check engine for multiplier benches.
- Computes one quotient bit per clock behind a start/done handshake.

---
 rtl/divider_32by16_seq.sv | 103 ++++++++++
 tb/tb_divider_32by16_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_32by16_seq.sv
// divider_32by16_seq
// Unsigned restoring divider, 32-bit dividend by 16-bit divisor.
// Produces one quotient bit per clock behind a start/done handshake.
// Feeding a 16x16 multiplier's product and operand B back in recovers
// operand A with a zero remainder.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for start; a zero divisor is answered from here
//   S_CALC | 32 shift/subtract iterations, one quotient bit per edge

module divider_32by16_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [15:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [15:0] remainder,
   output logic        div_by_zero
);

   typedef enum logic {S_IDLE, S_CALC} state_t;

   state_t      state;
   logic [4:0]  count;
   logic [15:0] dvs_q;
   logic [31:0] shreg;
   logic [16:0] prem;

   logic [16:0] prem_sh;
   logic [16:0] diff;
   logic        q_bit;
   logic [16:0] prem_nxt;
   logic [31:0] shreg_nxt;

   // One restoring iteration: shift in the next dividend bit, trial-subtract
   // the divisor, and keep the difference only if it did not go negative.
   // prem[16] is always zero in practice, but if it were set the shifted
   // value would exceed any 16-bit divisor, so it forces a 1 quotient bit.
   always_comb begin
      prem_sh   = {prem[15:0], shreg[31]};
      diff      = prem_sh - {1'b0, dvs_q};
      q_bit     = prem[16] | (prem_sh >= {1'b0, dvs_q});
      prem_nxt  = q_bit ? diff : prem_sh;
      shreg_nxt = {shreg[30:0], q_bit};
   end

   // Control FSM with registered outputs; result registers only change on
   // completion or on the divide-by-zero shortcut.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         count       <= '0;
         dvs_q       <= '0;
         shreg       <= '0;
         prem        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (divisor != 16'd0) begin
                     dvs_q <= divisor;
                     shreg <= dividend;
                     prem  <= '0;
                     count <= '0;
                     busy  <= 1'b1;
                     state <= S_CALC;
                  end else begin
                     quotient    <= 32'hFFFF_FFFF;
                     remainder   <= dividend[15:0];
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               shreg <= shreg_nxt;
               prem  <= prem_nxt;
               count <= count + 5'd1;
               if (count == 5'd31) begin
                  quotient    <= shreg_nxt;
                  remainder   <= prem_nxt[15:0];
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_32by16_seq.sv
// Directed and small random bench for divider_32by16_seq.
module tb_divider_32by16_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] last_q   = '0;

   divider_32by16_seq dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full operation from accept to done, with latency and hold checks.
   task automatic run_div(input logic [31:0] a, input logic [15:0] b,
                          input logic [31:0] eq, input logic [15:0] er,
                          input string tag);
      int cyc;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      start    = 1'b0;
      dividend = $urandom;
      divisor  = 16'($urandom);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_hold"}, 64'(quotient), 64'(last_q));
      cyc = 0;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
      end
      check({tag, "_lat"}, 64'(cyc), 64'd32);
      check({tag, "_q"}, 64'(quotient), 64'(eq));
      check({tag, "_r"}, 64'(remainder), 64'(er));
      check({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
      check({tag, "_inv"}, 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
      check({tag, "_rlt"}, 64'(remainder < b), 64'd1);
      last_q = eq;
      tick();
      check({tag, "_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int          cyc;
      logic        seen;
      logic [31:0] ra;
      logic [15:0] rb;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      tick();
      tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_q", 64'(quotient), 64'd0);
      check("rst_r", 64'(remainder), 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      rst = 1'b0;
      tick();

      run_div(32'd39812471, 16'd3943, 32'd10097, 16'd0, "mul_inv");

      // divide by zero answered in one clock
      start    = 1'b1;
      dividend = 32'h1234_5678;
      divisor  = 16'd0;
      tick();
      start = 1'b0;
      check("dbz_done", 64'(done), 64'd1);
      check("dbz_q", 64'(quotient), 64'hFFFF_FFFF);
      check("dbz_r", 64'(remainder), 64'h5678);
      check("dbz_flag", 64'(div_by_zero), 64'd1);
      check("dbz_busy", 64'(busy), 64'd0);
      last_q = 32'hFFFF_FFFF;
      tick();
      check("dbz_pulse", 64'(done), 64'd0);
      check("dbz_busy2", 64'(busy), 64'd0);
      check("dbz_hold", 64'(div_by_zero), 64'd1);

      run_div(32'd39812476, 16'd3943, 32'd10097, 16'd5, "rem5");
      run_div(32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'd0, "max_by1");
      run_div(32'hFFFF_FFFF, 16'hFFFF, 32'd65537, 16'd0, "max_bymax");
      run_div(32'd7, 16'd9, 32'd0, 16'd7, "small");

      // starts during CALC are ignored
      start    = 1'b1;
      dividend = 32'd1000000;
      divisor  = 16'd13;
      tick();
      start = 1'b0;
      repeat (4) tick();
      start    = 1'b1;
      dividend = 32'd5;
      divisor  = 16'd1;
      tick();
      start = 1'b0;
      repeat (14) tick();
      start    = 1'b1;
      dividend = 32'h0000_FFFF;
      divisor  = 16'd0;
      tick();
      start = 1'b0;
      cyc   = 20;
      while (!done && cyc < 40) begin
         tick();
         cyc++;
      end
      check("ign_lat", 64'(cyc), 64'd32);
      check("ign_q", 64'(quotient), 64'd76923);
      check("ign_r", 64'(remainder), 64'd1);
      check("ign_dbz", 64'(div_by_zero), 64'd0);
      tick();

      // start held through the done cycle: accepted one edge later
      start    = 1'b1;
      dividend = 32'd100;
      divisor  = 16'd7;
      tick();
      start    = 1'b0;
      dividend = 32'd39812476;
      divisor  = 16'd3943;
      repeat (31) tick();
      start = 1'b1;
      tick();
      check("b2b_done1", 64'(done), 64'd1);
      check("b2b_q1", 64'(quotient), 64'd14);
      check("b2b_r1", 64'(remainder), 64'd2);
      tick();
      start = 1'b0;
      check("b2b_busy2", 64'(busy), 64'd1);
      cyc = 1;
      while (!done && cyc < 45) begin
         tick();
         cyc++;
      end
      check("b2b_gap", 64'(cyc), 64'd33);
      check("b2b_q2", 64'(quotient), 64'd10097);
      check("b2b_r2", 64'(remainder), 64'd5);
      last_q = 32'd10097;
      tick();

      // reset during CALC aborts and clears results
      start    = 1'b1;
      dividend = 32'd39812471;
      divisor  = 16'd3943;
      tick();
      start = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_q", 64'(quotient), 64'd0);
      check("abort_r", 64'(remainder), 64'd0);
      check("abort_dbz", 64'(div_by_zero), 64'd0);
      last_q = '0;
      seen   = 1'b0;
      repeat (40) begin
         tick();
         if (done || busy) seen = 1'b1;
      end
      check("abort_quiet", 64'(seen), 64'd0);
      run_div(32'd100, 16'd7, 32'd14, 16'd2, "after_abort");

      // reset wins over a same-edge start
      rst      = 1'b1;
      start    = 1'b1;
      dividend = 32'h1234_5678;
      divisor  = 16'd0;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start_done", 64'(done), 64'd0);
      check("rst_start_dbz", 64'(div_by_zero), 64'd0);
      check("rst_start_q", 64'(quotient), 64'd0);
      last_q = '0;
      tick();

      for (int i = 0; i < 200; i++) begin
         ra = $urandom;
         rb = 16'($urandom_range(65535, 1));
         run_div(ra, rb, ra / 32'(rb), 16'(ra % 32'(rb)), "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
